alu_sched: RTL

- Arbitrates one shared integer ALU between two requesters: port 0 is the main decode path, port 1 is the address/branch helper.
- Each request carries operands a/b and the 11-bit function code {shamt, funct}.
- The block round-robins grants, registers operands, evaluates the op, and returns a tagged result on one shared response channel with valid/ready back-pressure.
- It sits between decode and writeback in the multi-cycle MIPS core.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_core.sv | 42 ++++
 rtl/alu_sched.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants and pipeline bundles for the alu_sched arbiter and its ALU.
// Function codes are the full 11-bit {shamt, funct} field from the MIPS R-type word.
package alu_pkg;

    localparam int XLEN = 32;
    localparam int NREQ = 2;
    localparam int FW   = 11;

    localparam logic [FW-1:0] FN_ADD  = 11'h020;
    localparam logic [FW-1:0] FN_SUB  = 11'h022;
    localparam logic [FW-1:0] FN_AND  = 11'h024;
    localparam logic [FW-1:0] FN_OR   = 11'h025;
    localparam logic [FW-1:0] FN_XOR  = 11'h026;
    localparam logic [FW-1:0] FN_SLT  = 11'h02A;
    localparam logic [FW-1:0] FN_MOVZ = 11'h00A;

    // funct bits of the code; all-zero funct selects SLL with shamt in f[10:6]
    localparam logic [FW-1:0] SHIFT_MASK = 11'h03F;

    typedef struct packed {
        logic            valid;
        logic            id;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [FW-1:0]   f;
    } s1_t;

    typedef struct packed {
        logic            valid;
        logic            id;
        logic [XLEN-1:0] data;
        logic            we;
        logic            illegal;
    } s2_t;

endpackage

// File: rtl/alu_core.sv
// Combinational integer ALU sitting between the operand and result registers.
// Unsupported codes return zero data with writeback suppressed and illegal flagged.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [FW-1:0] f,
    output logic [W-1:0]  data,
    output logic          we,
    output logic          illegal
);

    always_comb begin
        data    = '0;
        we      = 1'b1;
        illegal = 1'b0;
        if ((f & SHIFT_MASK) == '0) begin
            data = b << f[10:6];
        end else begin
            case (f)
                FN_ADD:  data = a + b;
                FN_SUB:  data = a - b;
                FN_AND:  data = a & b;
                FN_OR:   data = a | b;
                FN_XOR:  data = a ^ b;
                FN_SLT:  data = {{(W-1){1'b0}}, (a < b)};
                FN_MOVZ: begin
                    data = a;
                    we   = (b == '0);
                end
                default: begin
                    we      = 1'b0;
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Two-requester round-robin front end for one shared ALU, two-stage pipeline, one response channel.
// Build with ALU_SCHED_PERF_EN defined to get grant and stall counters on perf_*.
module alu_sched
    import alu_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [W-1:0]    req0_a,
    input  logic [W-1:0]    req0_b,
    input  logic [FW-1:0]   req0_f,
    input  logic [W-1:0]    req1_a,
    input  logic [W-1:0]    req1_b,
    input  logic [FW-1:0]   req1_f,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [W-1:0]    rsp_data,
    output logic            rsp_we,
    output logic            rsp_illegal,
    output logic [31:0]     perf_grants0,
    output logic [31:0]     perf_grants1,
    output logic [31:0]     perf_stall
);

    // Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i];
    // a result transfers where rsp_valid & rsp_ready. rsp_* hold while rsp_valid & !rsp_ready.
    s1_t          r_s1;
    s2_t          r_s2;
    logic         r_ptr;
    logic         w_adv1;
    logic         w_adv2;
    logic [1:0]   w_gnt;
    logic [W-1:0] w_data;
    logic         w_we;
    logic         w_illegal;

    assign w_adv2 = !r_s2.valid || rsp_ready;
    assign w_adv1 = !r_s1.valid || w_adv2;

    always_comb begin
        w_gnt = 2'b00;
        if (w_adv1 && !flush) begin
            if (req_valid[0] && (!req_valid[1] || !r_ptr)) begin
                w_gnt = 2'b01;
            end else if (req_valid[1]) begin
                w_gnt = 2'b10;
            end
        end
    end

    assign req_ready = w_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1  <= '0;
            r_ptr <= 1'b0;
        end else if (flush) begin
            r_s1.valid <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_s1.valid <= |w_gnt;
                if (w_gnt[1]) begin
                    r_s1.id <= 1'b1;
                    r_s1.a  <= req1_a;
                    r_s1.b  <= req1_b;
                    r_s1.f  <= req1_f;
                end else if (w_gnt[0]) begin
                    r_s1.id <= 1'b0;
                    r_s1.a  <= req0_a;
                    r_s1.b  <= req0_b;
                    r_s1.f  <= req0_f;
                end
            end
            if (w_gnt[0]) r_ptr <= 1'b1;
            else if (w_gnt[1]) r_ptr <= 1'b0;
        end
    end

    alu_core #(.W(W)) u_alu (
        .a       (r_s1.a),
        .b       (r_s1.b),
        .f       (r_s1.f),
        .data    (w_data),
        .we      (w_we),
        .illegal (w_illegal)
    );

    // Payload only loads with a real op so a drained response keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2 <= '0;
        end else if (flush) begin
            r_s2.valid <= 1'b0;
        end else if (w_adv2) begin
            r_s2.valid <= r_s1.valid;
            if (r_s1.valid) begin
                r_s2.id      <= r_s1.id;
                r_s2.data    <= w_data;
                r_s2.we      <= w_we;
                r_s2.illegal <= w_illegal;
            end
        end
    end

    assign rsp_valid   = r_s2.valid;
    assign rsp_id      = r_s2.id;
    assign rsp_data    = r_s2.data;
    assign rsp_we      = r_s2.we;
    assign rsp_illegal = r_s2.illegal;

`ifdef ALU_SCHED_PERF_EN
    logic [31:0] r_grants0;
    logic [31:0] r_grants1;
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grants0 <= '0;
            r_grants1 <= '0;
            r_stall   <= '0;
        end else begin
            if (w_gnt[0]) r_grants0 <= r_grants0 + 32'd1;
            if (w_gnt[1]) r_grants1 <= r_grants1 + 32'd1;
            if (r_s2.valid && !rsp_ready) r_stall <= r_stall + 32'd1;
        end
    end

    assign perf_grants0 = r_grants0;
    assign perf_grants1 = r_grants1;
    assign perf_stall   = r_stall;
`else
    assign perf_grants0 = '0;
    assign perf_grants1 = '0;
    assign perf_stall   = '0;
`endif

endmodule
